data_mem_sized: RTL



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_lane_fmt.sv | 62 ++++++
 rtl/data_mem_sized.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the sized MEM-stage data memory.
//   - access size encodings (SZ_B, SZ_H, SZ_W; 2'b11 is handled as a word)
//   - clearing/run state enum for the top-level sequencer
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational lane formatter shared by the store and load paths.
// Ports:
//   size_i[1:0]        access size (byte/half/word, 2'b11 = word)
//   offset_i[1:0]      byte offset within the word (addr[1:0])
//   unsigned_ld_i      1 = zero-extend loads, 0 = sign-extend
//   store_data_i[31:0] right-justified store data
//   load_word_i[31:0]  word read from the array
//   byte_en_o[3:0]     per-lane store enables
//   store_lane_o[31:0] store data replicated onto its target lanes
//   load_ext_o[31:0]   extracted and extended load result
// Halfword uses only offset_i[1]; word ignores offset_i, so low bits are
// effectively forced aligned. Misalignment policy lives in the top.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_ld_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_lane_o,
    output logic [31:0] load_ext_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        unique case (offset_i)
            2'd0:    ld_byte = load_word_i[7:0];
            2'd1:    ld_byte = load_word_i[15:8];
            2'd2:    ld_byte = load_word_i[23:16];
            default: ld_byte = load_word_i[31:24];
        endcase
        ld_half = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    end

    always_comb begin
        byte_en_o    = 4'b0000;
        store_lane_o = '0;
        load_ext_o   = '0;
        case (size_i)
            SZ_B: begin
                byte_en_o    = 4'b0001 << offset_i;
                store_lane_o = {4{store_data_i[7:0]}};
                load_ext_o   = {{24{ld_byte[7] & ~unsigned_ld_i}}, ld_byte};
            end
            SZ_H: begin
                byte_en_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                store_lane_o = {2{store_data_i[15:0]}};
                load_ext_o   = {{16{ld_half[15] & ~unsigned_ld_i}}, ld_half};
            end
            default: begin
                byte_en_o    = 4'b1111;
                store_lane_o = store_data_i;
                load_ext_o   = load_word_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// data_mem_sized: single-ported MEM-stage data memory with byte/half/word
// access, sign/zero-extended registered loads and a post-reset clearing pass.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load / store request (both high = store only)
//   size[1:0]             00 byte, 01 half, 10/11 word
//   unsigned_ld           zero-extend loads when 1
//   addr[31:0]            byte address, aliases modulo 4*DEPTH
//   write_data[31:0]      right-justified store data
//   read_data[31:0]       load result, 0 unless rd_valid
//   rd_valid              load data strobe, one cycle after the request
//   ready                 0 while the array is being cleared
//   misalign              misaligned-access strobe, same timing as rd_valid
// Build option: define DMEM_MISALIGN_TRAP_EN to flag and suppress misaligned
// halfword/word accesses; otherwise low address bits are forced aligned.
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        rd_valid,
    output logic        ready,
    output logic        misalign
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0]      mem_q [DEPTH];
    dmem_state_e      state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             ready_q;
    logic             rd_valid_q;
    logic [31:0]      read_data_q;
    logic             misalign_q;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic             ld_acc;
    logic             st_acc;
    logic             mis;
    logic [3:0]       byte_en;
    logic [31:0]      store_lane;
    logic [31:0]      load_ext;
    logic             unused_addr;

    assign word_idx    = addr[IDX_W+1:2];
    assign offset      = addr[1:0];
    assign unused_addr = ^addr[31:IDX_W+2];

    // A simultaneous read+write is a store only.
    assign st_acc = ready_q & mem_write;
    assign ld_acc = ready_q & mem_read & ~mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    dmem_lane_fmt u_lane_fmt (
        .size_i        (size),
        .offset_i      (offset),
        .unsigned_ld_i (unsigned_ld),
        .store_data_i  (write_data),
        .load_word_i   (mem_q[word_idx]),
        .byte_en_o     (byte_en),
        .store_lane_o  (store_lane),
        .load_ext_o    (load_ext)
    );

    // Sequencer and registered outputs. Reset drops any in-flight load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            read_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            rd_valid_q  <= ld_acc;
            read_data_q <= (ld_acc && !mis) ? load_ext : '0;
            misalign_q  <= (ld_acc || st_acc) && mis;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: ;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // Array has no reset; the clearing pass zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (st_acc && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= store_lane[8*i +: 8];
                end
            end
        end
    end

    assign read_data = read_data_q;
    assign rd_valid  = rd_valid_q;
    assign ready     = ready_q;
    assign misalign  = misalign_q;

endmodule
